// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-organised memory between instruction fetch (IF) and load/store (LS).
// Optional macro MEM_ARB_RR_EN selects round-robin contention instead of LS priority with IF starvation override.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_ls_req,
  input  logic        i_ls_we,
  input  logic [31:0] i_ls_addr,
  input  logic [31:0] i_ls_wdata,
  input  logic [1:0]  i_ls_size,
  input  logic        i_ls_unsigned,
  output logic        o_ls_gnt,
  output logic        o_ls_rvalid,
  output logic [31:0] o_ls_rdata,
  output logic        o_ls_misalign,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  output logic        o_mem_wren,
  input  logic [31:0] i_mem_rdata
);

  function automatic logic f_misalign(input logic [1:0] size, input logic [1:0] off);
    logic w_mis;
    case (size)
      2'b00:   w_mis = 1'b0;
      2'b01:   w_mis = off[0];
      2'b10:   w_mis = (off != 2'b00);
      default: w_mis = 1'b1;
    endcase
    return w_mis;
  endfunction

  function automatic logic [3:0] f_bmask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] w_mask;
    case (size)
      2'b00:   w_mask = 4'b0001 << off;
      2'b01:   w_mask = 4'b0011 << off;
      2'b10:   w_mask = 4'b1111;
      default: w_mask = 4'b0000;
    endcase
    return w_mask;
  endfunction

  function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] w_rep;
    case (size)
      2'b00:   w_rep = {4{data[7:0]}};
      2'b01:   w_rep = {2{data[15:0]}};
      default: w_rep = data;
    endcase
    return w_rep;
  endfunction

  // Lane select follows the byte offset; halves only ever sit on 16-bit lanes.
  function automatic logic [31:0] f_load_ext(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] off, input logic uns);
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;
    w_byte = 8'(word >> {off, 3'b000});
    w_half = 16'(word >> {off[1], 4'b0000});
    case (size)
      2'b00:   w_ext = uns ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_ext = uns ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
      default: w_ext = word;
    endcase
    return w_ext;
  endfunction

  logic        w_if_pri;
  logic        w_if_win;
  logic        w_ls_win;
  logic        w_ls_mis;
  logic        r_if_rvalid;
  logic [31:0] r_if_rdata;
  logic        r_ls_rvalid;
  logic [31:0] r_ls_rdata;
  logic        r_ls_misalign;

`ifdef MEM_ARB_RR_EN
  typedef enum logic {SEL_LS = 1'b0, SEL_IF = 1'b1} sel_e;
  sel_e r_rr_ptr;
  sel_e w_rr_ptr_nxt;

  // Preferred-requester pointer register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rr_ptr <= SEL_LS;
    end else begin
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // Pointer hands preference to the loser after every contended grant.
  always_comb begin
    w_if_pri     = (r_rr_ptr == SEL_IF);
    w_rr_ptr_nxt = r_rr_ptr;
    if (i_if_req && i_ls_req) begin
      w_rr_ptr_nxt = w_if_win ? SEL_LS : SEL_IF;
    end else begin
      w_rr_ptr_nxt = r_rr_ptr;
    end
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] r_starve_cnt;
  logic [3:0] w_starve_nxt;

  // Consecutive-denial counter register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_starve_cnt <= 4'd0;
    end else begin
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // IF jumps the LS priority once it has been refused LIMIT cycles in a row.
  always_comb begin
    w_if_pri     = (r_starve_cnt == LIMIT);
    w_starve_nxt = r_starve_cnt;
    if (!i_if_req || w_if_win) begin
      w_starve_nxt = 4'd0;
    end else if (r_starve_cnt < LIMIT) begin
      w_starve_nxt = r_starve_cnt + 4'd1;
    end else begin
      w_starve_nxt = r_starve_cnt;
    end
  end
`endif

  // Grant decision and memory-side drive.
  always_comb begin
    w_if_win    = i_if_req & (~i_ls_req | w_if_pri);
    w_ls_win    = i_ls_req & ~w_if_win;
    w_ls_mis    = f_misalign(i_ls_size, i_ls_addr[1:0]);
    o_if_gnt    = w_if_win;
    o_ls_gnt    = w_ls_win;
    o_mem_addr  = w_if_win ? (i_if_addr & 32'hFFFF_FFFC) : i_ls_addr;
    o_mem_wdata = f_wdata(i_ls_size, i_ls_wdata);
    o_mem_wren  = w_ls_win & i_ls_we & ~w_ls_mis;
    o_mem_bmask = o_mem_wren ? f_bmask(i_ls_size, i_ls_addr[1:0]) : 4'b0000;
  end

  // Response registers, presented the cycle after the grant.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_if_rvalid   <= 1'b0;
      r_if_rdata    <= 32'h0000_0000;
      r_ls_rvalid   <= 1'b0;
      r_ls_rdata    <= 32'h0000_0000;
      r_ls_misalign <= 1'b0;
    end else begin
      r_if_rvalid   <= w_if_win;
      r_ls_rvalid   <= w_ls_win;
      r_ls_misalign <= w_ls_win & w_ls_mis;
      if (w_if_win) begin
        r_if_rdata <= i_mem_rdata;
      end
      if (w_ls_win) begin
        r_ls_rdata <= (i_ls_we | w_ls_mis) ? 32'h0000_0000
                    : f_load_ext(i_mem_rdata, i_ls_size, i_ls_addr[1:0], i_ls_unsigned);
      end
    end
  end

  assign o_if_rvalid   = r_if_rvalid;
  assign o_if_rdata    = r_if_rdata;
  assign o_ls_rvalid   = r_ls_rvalid;
  assign o_ls_rdata    = r_ls_rdata;
  assign o_ls_misalign = r_ls_misalign;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench with a byte-level reference model checked every cycle.
// Honours MEM_ARB_RR_EN to switch the expected contention order.
module tb_mem_arbiter;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, if_gnt, if_rvalid;
  logic [31:0] if_addr = 32'h0, if_rdata;
  logic        ls_req = 1'b0, ls_we = 1'b0, ls_unsigned = 1'b0, ls_gnt, ls_rvalid, ls_misalign;
  logic [31:0] ls_addr = 32'h0, ls_wdata = 32'h0, ls_rdata;
  logic [1:0]  ls_size = 2'b00;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_bmask;
  logic        mem_wren;

  logic [31:0] mem [64];
  logic [7:0]  ref_b [256];
  logic [31:0] wtmp;
  int n_checks = 0, n_errors = 0;

  logic [31:0] g_bmask, g_wdata, g_rdata, saved;
  logic        g_wren, g_mis, g_rvalid;

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt),
    .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
    .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
    .i_ls_size(ls_size), .i_ls_unsigned(ls_unsigned), .o_ls_gnt(ls_gnt),
    .o_ls_rvalid(ls_rvalid), .o_ls_rdata(ls_rdata), .o_ls_misalign(ls_misalign),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_bmask(mem_bmask),
    .o_mem_wren(mem_wren), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_wren) begin
      wtmp = mem[mem_addr[7:2]];
      for (int i = 0; i < 4; i++) if (mem_bmask[i]) wtmp[8*i +: 8] = mem_wdata[8*i +: 8];
      mem[mem_addr[7:2]] <= wtmp;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Little-endian read of nb bytes from the reference image, then sign/zero extension.
  function automatic logic [31:0] ref_load(input int a, input int size, input bit uns);
    int nb;
    longint v;
    nb = 1 << size;
    v = 0;
    for (int i = 0; i < nb; i++) v = v + (longint'(ref_b[(a + i) % 256]) << (8 * i));
    if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  int          m_starve = 0;
  bit          m_pref_if = 1'b0;
  bit          p_if = 1'b0, p_ls = 1'b0, p_mis = 1'b0;
  logic [31:0] p_if_data, p_ls_data;

  always @(negedge clk) begin
    bit e_if, e_ls, mis;
    int sz, off, nb, a;
    logic [3:0] eb;
    if (rst) begin
      chk("rst_if_rvalid", if_rvalid, 0);
      chk("rst_ls_rvalid", ls_rvalid, 0);
      chk("rst_ls_misalign", ls_misalign, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_ls_rdata", ls_rdata, 0);
      m_starve = 0; m_pref_if = 1'b0; p_if = 1'b0; p_ls = 1'b0;
    end else begin
      chk("if_rvalid", if_rvalid, p_if);
      if (p_if) chk("if_rdata", if_rdata, p_if_data);
      chk("ls_rvalid", ls_rvalid, p_ls);
      if (p_ls) begin
        chk("ls_misalign", ls_misalign, p_mis);
        chk("ls_rdata", ls_rdata, p_ls_data);
      end
    end
`ifdef MEM_ARB_RR_EN
    e_if = if_req && (!ls_req || m_pref_if);
`else
    e_if = if_req && (!ls_req || m_starve == STARVE_LIMIT);
`endif
    e_ls = ls_req && !e_if;
    chk("if_gnt", if_gnt, e_if);
    chk("ls_gnt", ls_gnt, e_ls);
    sz  = int'(ls_size);
    a   = int'(ls_addr % 256);
    off = a % 4;
    nb  = 1 << sz;
    mis = (sz == 3) || (sz == 1 && off % 2 != 0) || (sz == 2 && off != 0);
    if (e_if) begin
      chk("if_mem_addr", mem_addr, if_addr & ~32'h3);
      chk("if_mem_bmask", mem_bmask, 0);
      chk("if_mem_wren", mem_wren, 0);
    end else if (e_ls) begin
      chk("ls_mem_addr", mem_addr, ls_addr);
      chk("ls_mem_wren", mem_wren, ls_we && !mis);
      if (mis) chk("mis_mem_bmask", mem_bmask, 0);
      else if (ls_we) begin
        eb = 4'(((1 << nb) - 1) << off);
        chk("st_mem_bmask", mem_bmask, eb);
        if (nb == 1) chk("st_mem_wdata", mem_wdata, ls_wdata[7:0] * 32'h0101_0101);
        else if (nb == 2) chk("st_mem_wdata", mem_wdata, ls_wdata[15:0] * 32'h0001_0001);
        else chk("st_mem_wdata", mem_wdata, ls_wdata);
      end
    end else begin
      chk("idle_mem_wren", mem_wren, 0);
    end
    if (!rst) begin
      p_if = e_if;
      if (e_if) p_if_data = ref_load(int'(if_addr % 256) & 252, 2, 1'b1);
      p_ls  = e_ls;
      p_mis = mis;
      p_ls_data = (ls_we || mis) ? 32'h0 : ref_load(a, sz, ls_unsigned);
      if (e_ls && ls_we && !mis)
        for (int i = 0; i < nb; i++) ref_b[(a + i) % 256] = ls_wdata[8*i +: 8];
      if (!if_req || e_if) m_starve = 0;
      else if (m_starve < STARVE_LIMIT) m_starve++;
      if (if_req && ls_req) m_pref_if = !e_if;
    end
  end

  task automatic set_word(input int idx, input logic [31:0] w);
    mem[idx] = w;
    for (int j = 0; j < 4; j++) ref_b[4*idx + j] = w[8*j +: 8];
  endtask

  task automatic ls_op(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] size, input bit uns);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    ls_we = we; ls_addr = addr; ls_wdata = wd; ls_size = size; ls_unsigned = uns; ls_req = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk); #2;
      if (ls_gnt) begin
        got = 1'b1; g_bmask = {28'h0, mem_bmask}; g_wdata = mem_wdata; g_wren = mem_wren;
      end
    end
    chk("ls_gnt_wait", got, 1);
    @(posedge clk); #1;
    ls_req = 1'b0;
    @(negedge clk); #2;
    g_rvalid = ls_rvalid; g_rdata = ls_rdata; g_mis = ls_misalign;
  endtask

  task automatic if_read(input logic [31:0] addr);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    if_addr = addr; if_req = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk); #2;
      if (if_gnt) got = 1'b1;
    end
    chk("if_gnt_wait", got, 1);
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk); #2;
    g_rvalid = if_rvalid; g_rdata = if_rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_ls;
    for (int i = 0; i < 64; i++) set_word(i, $urandom);
    set_word(4, 32'hDEAD_BEEF);
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    chk("lit_rst_gnt", {if_gnt, ls_gnt, mem_wren}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    if_read(32'h10);
    chk("lit_if_rvalid", g_rvalid, 1);
    chk("lit_if_rdata", g_rdata, 32'hDEAD_BEEF);

    ls_op(1'b1, 32'h22, 32'h1234_56A5, 2'b00, 1'b0);
    chk("lit_sb_bmask", g_bmask, 32'h4);
    chk("lit_sb_wdata", g_wdata, 32'hA5A5_A5A5);
    chk("lit_sb_wren", g_wren, 1);
    chk("lit_sb_resp", {g_rvalid, g_mis}, 2'b10);
    chk("lit_sb_rdata", g_rdata, 0);
    ls_op(1'b0, 32'h22, 32'h0, 2'b00, 1'b0);
    chk("lit_lb_signed", g_rdata, 32'hFFFF_FFA5);
    ls_op(1'b0, 32'h22, 32'h0, 2'b00, 1'b1);
    chk("lit_lb_unsigned", g_rdata, 32'h0000_00A5);

    ls_op(1'b1, 32'h42, 32'h1234_BEEF, 2'b01, 1'b0);
    chk("lit_sh_bmask", g_bmask, 32'hC);
    chk("lit_sh_wdata", g_wdata, 32'hBEEF_BEEF);
    ls_op(1'b0, 32'h42, 32'h0, 2'b01, 1'b0);
    chk("lit_lh_signed", g_rdata, 32'hFFFF_BEEF);
    ls_op(1'b0, 32'h42, 32'h0, 2'b01, 1'b1);
    chk("lit_lh_unsigned", g_rdata, 32'h0000_BEEF);

    ls_op(1'b1, 32'h30, 32'h8001_7F00, 2'b10, 1'b0);
    chk("lit_sw_bmask", g_bmask, 32'hF);
    ls_op(1'b0, 32'h31, 32'h0, 2'b00, 1'b0);
    chk("lit_lb_pos", g_rdata, 32'h0000_007F);
    ls_op(1'b0, 32'h33, 32'h0, 2'b00, 1'b0);
    chk("lit_lb_neg", g_rdata, 32'hFFFF_FF80);

    ls_op(1'b0, 32'h43, 32'h0, 2'b01, 1'b0);
    chk("lit_mis_half_resp", {g_rvalid, g_mis}, 2'b11);
    chk("lit_mis_half_rdata", g_rdata, 0);
    chk("lit_mis_half_wren", g_wren, 0);
    saved = mem[17];
    ls_op(1'b1, 32'h46, 32'hCAFE_F00D, 2'b10, 1'b0);
    chk("lit_mis_word_resp", {g_rvalid, g_mis, g_wren}, 3'b110);
    chk("lit_mis_word_mem", mem[17], saved);
    ls_op(1'b0, 32'h40, 32'h0, 2'b11, 1'b0);
    chk("lit_mis_size3", g_mis, 1);

    // Load granted, then reset lands before its response edge.
    @(posedge clk); #1;
    ls_we = 1'b0; ls_addr = 32'h30; ls_size = 2'b10; ls_unsigned = 1'b0; ls_req = 1'b1;
    @(negedge clk); #2;
    chk("lit_rst_mid_gnt", ls_gnt, 1);
    rst = 1'b1; ls_req = 1'b0;
    @(negedge clk); #2;
    chk("lit_rst_mid_rvalid", ls_rvalid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    if_addr = 32'h10; if_req = 1'b1;
    ls_we = 1'b0; ls_addr = 32'h30; ls_size = 2'b10; ls_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #2;
`ifdef MEM_ARB_RR_EN
      exp_ls = (k % 2 == 0);
`else
      exp_ls = (k % (STARVE_LIMIT + 1) != STARVE_LIMIT);
`endif
      chk($sformatf("lit_contend_%0d", k), {if_gnt, ls_gnt}, {!exp_ls, exp_ls});
    end
    @(posedge clk); #1;
    if_req = 1'b0; ls_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
